// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator.
// Mode codes and the heartbeat frame; frame bit p is the LED level at phase p.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF       = 2'b00;
  localparam mode_t MODE_ON        = 2'b01;
  localparam mode_t MODE_BLINK     = 2'b10;
  localparam mode_t MODE_HEARTBEAT = 2'b11;

  localparam logic [7:0] HB_FRAME = 8'b0000_0101;

endpackage

// File: rtl/led_prescaler.sv
// Free-running clock prescaler: tick is high for one cycle out of every DIV.
// With DIV=1 the counter never leaves 0 and tick stays high.
module led_prescaler #(
  parameter int unsigned DIV   = 500000,
  parameter int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: OFF/ON/BLINK/HEARTBEAT, mode changes applied on prescaler ticks.
// Define LED_PATTERN_HEARTBEAT_EN for a true heartbeat; otherwise mode 11 acts as BLINK.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned DIV   = 500000,
  parameter int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       mode_load,
  output logic       busy,
  output logic       tick,
  output logic       led_out
);

`ifdef LED_PATTERN_HEARTBEAT_EN
  localparam int unsigned PhaseW = 3;
`else
  localparam int unsigned PhaseW = 1;
`endif

  typedef logic [PhaseW-1:0] phase_t;

  function automatic logic pat(mode_t m, phase_t p);
    logic r;
    case (m)
      MODE_OFF:       r = 1'b0;
      MODE_ON:        r = 1'b1;
`ifdef LED_PATTERN_HEARTBEAT_EN
      MODE_HEARTBEAT: r = HB_FRAME[p];
`endif
      default:        r = ~p[0];
    endcase
    return r;
  endfunction

  logic   pend_q, pend_d;
  mode_t  pend_mode_q, pend_mode_d;
  mode_t  cur_mode_q, cur_mode_d;
  phase_t phase_q, phase_d;
  phase_t phase_inc;
  logic   led_q, led_d;

  led_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    cur_mode_d  = cur_mode_q;
    phase_d     = phase_q;
    led_d       = led_q;
    phase_inc   = phase_q + phase_t'(1);

    if (tick) begin
      // A load landing on the tick defers the switch to the following tick.
      if (pend_q && !mode_load) begin
        cur_mode_d = pend_mode_q;
        phase_d    = '0;
        led_d      = pat(pend_mode_q, '0);
        pend_d     = 1'b0;
      end else begin
        phase_d = phase_inc;
        led_d   = pat(cur_mode_q, phase_inc);
      end
    end

    if (mode_load) begin
      pend_d      = 1'b1;
      pend_mode_d = mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_mode_q <= MODE_OFF;
      cur_mode_q  <= MODE_OFF;
      phase_q     <= '0;
      led_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      cur_mode_q  <= cur_mode_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

  assign busy    = pend_q;
  assign led_out = led_q;

endmodule
